regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug readout engine: on a start pulse, walks all architectural registers of the pipeline register file through a spare read port and streams each word out over a valid/ready channel. It is the reader-side counterpart of the register file's write path. It sits beside the register file, driving a third read address and consuming the combinational read data. Test benches and the debug/trace logic use it to dump architectural state without stalling the pipeline.

## Interface
Parameters:
- NUM_REGS, 32: number of registers walked, indices 0..NUM_REGS-1.
- ADDR_W, 5: register index width, with NUM_REGS <= 2**ADDR_W.
- DATA_W, 32: register word width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request to begin a dump; ignored while busy=1.
- rd_addr  out  ADDR_W  read address to the register file's spare read port.
- rd_data  in  DATA_W  combinational read data for rd_addr.
- out_valid  out  1  a beat is presented on out_data/out_idx.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready at posedge.
- out_data  out  DATA_W  register value, or checksum on the checksum beat.
- out_idx  out  ADDR_W  register index of the beat; 0 on the checksum beat.
- out_last  out  1  marks the final beat of a dump.
- out_csum  out  1  marks the checksum beat; constant 0 without the macro.
- busy  out  1  dump in progress (FETCH, SEND, or CSUM).
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, FETCH, SEND, CSUM.
- IDLE: busy=0. When start=1, set idx<=0 and go to FETCH.
- FETCH, one cycle: rd_addr=idx. At the posedge, out_data<=rd_data, out_idx<=idx, out_last<=(idx==NUM_REGS-1 && no checksum), out_valid<=1, and go to SEND.
- SEND: out_valid, out_data, out_idx and out_last stay stable until accepted. On acceptance:
  - if idx==NUM_REGS-1: go to CSUM if enabled, else IDLE with done pulse;
  - otherwise idx<=idx+1 and go to FETCH.
- CSUM: presents the accumulated XOR with out_csum=1, out_last=1, out_idx=0. On acceptance go to IDLE and pulse done.
- rd_addr = idx in every state; it is 0 in IDLE.
- No snapshot: each word is the register value at its FETCH capture edge. Register file writes occur on negedge, so read data is stable at posedge.
- start during busy is dropped, not queued. start in the done cycle begins a new dump, because the block is already in IDLE.
- Register 0 is dumped like any other register; it reads 0.

## Timing
- start sampled at edge k → FETCH during cycle k+1 → out_valid=1 from edge k+2.
- Per-beat cost is 2 cycles with out_ready held 1: FETCH plus SEND.
- Full dump latency from start to done is 2*NUM_REGS+1 cycles, or +1 with checksum, at full throughput.
- out_ready low holds the beat indefinitely; the data must not change.
- done is high for exactly the cycle after the last acceptance edge.
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, out_csum=0, busy=0, done=0, rd_addr=0, state IDLE, idx=0, accumulator=0.
- Reset mid-dump: immediate abort to IDLE. No done, no partial checksum beat.

## Configuration
- REGDUMP_CHECKSUM_EN defined: an accumulator XORs every accepted register word and resets to 0 on start. One extra CSUM beat follows register NUM_REGS-1, and out_last moves to that beat.
- Undefined: no accumulator and no CSUM state. out_csum is tied to 0, and out_last rides on register NUM_REGS-1.

## Structure
- Package regdump_pkg holds the state enum (IDLE/FETCH/SEND/CSUM) and the default NUM_REGS/ADDR_W/DATA_W constants.
- Optional sub-module regdump_csum holds the XOR accumulator, with clear/enable/data_in/sum_out. It is instantiated only under REGDUMP_CHECKSUM_EN.

## Test plan
- Preload reg[i]=i*32'h01010101 and pulse start with out_ready=1 → 32 beats with out_idx 0..31 and the matching data; out_last on idx 31; done 65 cycles after start.
- Drop out_ready for 3 cycles while idx=7 is presented → out_data=32'h07070707 held stable for all 3 cycles; no beat lost or duplicated.
- Pulse start again during idx=10 → ignored; the stream continues 11..31 and exactly one done pulse occurs.
- Assert rst=0 while idx=15 is presented → next cycle all outputs are 0 and busy=0; no done; a fresh start dumps from idx 0.
- With REGDUMP_CHECKSUM_EN and the same preload → 33rd beat has out_csum=1, out_last=1, out_idx=0, out_data = XOR of all 32 words.
- Write reg[20]=32'hDEADBEEF via the write port mid-dump, before idx 20 is fetched → beat 20 carries 32'hDEADBEEF.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// regfile_dump package: walker state encoding and default geometry.
package regdump_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM
    } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump output stream: valid/ready beat channel carrying one register
// word (or the checksum word) per beat.
interface regfile_dump_if
#(
    parameter int ADDR_W = regdump_pkg::DEF_ADDR_W,
    parameter int DATA_W = regdump_pkg::DEF_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              out_csum;

    modport master (
        output out_valid, out_data, out_idx, out_last, out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last, out_csum,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_csum.sv
// regdump_csum: XOR accumulator over accepted register words.
// Only instantiated when REGDUMP_CHECKSUM_EN is defined.
module regdump_csum
    import regdump_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] sum_out
);
    logic [DATA_W-1:0] r_sum;

    // Accumulate; a clear (new dump) takes priority over accumulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (clear) begin
            r_sum <= '0;
        end else if (enable) begin
            r_sum <= r_sum ^ data_in;
        end
    end

    assign sum_out = r_sum;
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks registers 0..NUM_REGS-1 through a spare read port and
// streams each word over a valid/ready channel.
// Optional: REGDUMP_CHECKSUM_EN appends an XOR checksum beat after the last
// register and moves out_last onto it.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    regfile_dump_if.master    out_bus,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_idx;
    logic              r_out_last;
    logic              r_done;
    logic              w_accept;
    logic              w_at_last;
    logic              w_final;

    assign w_accept  = r_out_valid & out_bus.out_ready;
    assign w_at_last = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; w_final flags acceptance of the dump's final beat.
    always_comb begin
        w_state_nxt = r_state;
        w_final     = 1'b0;
        case (r_state)
            IDLE:  if (start) w_state_nxt = FETCH;
            FETCH: w_state_nxt = SEND;
            SEND: begin
                if (w_accept) begin
                    if (w_at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
                        w_state_nxt = CSUM;
`else
                        w_state_nxt = IDLE;
                        w_final     = 1'b1;
`endif
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end
            end
            CSUM: begin
`ifdef REGDUMP_CHECKSUM_EN
                if (w_accept) begin
                    w_state_nxt = IDLE;
                    w_final     = 1'b1;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic              r_out_csum;
    logic [DATA_W-1:0] w_csum_sum;

    regdump_csum #(.DATA_W(DATA_W)) u_csum (
        .clk     (clk),
        .rst     (rst),
        .clear   ((r_state == IDLE) && start),
        .enable  ((r_state == SEND) && w_accept),
        .data_in (r_out_data),
        .sum_out (w_csum_sum)
    );
`endif

    // Index walk and beat capture; beat fields hold until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_out_csum  <= 1'b0;
`endif
        end else begin
            r_done <= w_final;
            case (r_state)
                IDLE: if (start) r_idx <= '0;
                FETCH: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= rd_data;
                    r_out_idx   <= r_idx;
`ifdef REGDUMP_CHECKSUM_EN
                    r_out_last  <= 1'b0;
`else
                    r_out_last  <= w_at_last;
`endif
                end
                SEND: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (w_at_last) begin
                            // Return idx to 0 so rd_addr reads 0 while idle.
                            r_idx <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                            r_out_valid <= 1'b1;
                            r_out_idx   <= '0;
                            r_out_last  <= 1'b1;
                            r_out_csum  <= 1'b1;
`else
                            r_out_last  <= 1'b0;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                CSUM: begin
`ifdef REGDUMP_CHECKSUM_EN
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_csum  <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign rd_addr           = r_idx;
    assign busy              = (r_state != IDLE);
    assign done              = r_done;
    assign out_bus.out_valid = r_out_valid;
    assign out_bus.out_idx   = r_out_idx;
    assign out_bus.out_last  = r_out_last;
`ifdef REGDUMP_CHECKSUM_EN
    // The accumulator already holds the last word once CSUM is entered.
    assign out_bus.out_data  = r_out_csum ? w_csum_sum : r_out_data;
    assign out_bus.out_csum  = r_out_csum;
`else
    assign out_bus.out_data  = r_out_data;
    assign out_bus.out_csum  = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: a behavioural register file feeds the spare
// read port; a reference model predicts every beat, done and busy.
module tb_regfile_dump;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NB = N + CS;
    localparam int BW = AW + DW + 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] mem [N];
    int            vecs = 0;
    int            errs = 0;

    regfile_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .out_bus (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Register file read port; register 0 is always held at 0 in mem.
    assign rd_data = mem[rd_addr];

    // Expected beat k of a dump as {last, csum, idx, data}.
    function automatic logic [BW-1:0] exp_beat(input int k);
        logic [DW-1:0] x;
        x = '0;
        if (k < N) return {(k == N - 1 && CS == 0), 1'b0, AW'(k), mem[k]};
        for (int i = 0; i < N; i++) x ^= mem[i];
        return {1'b1, 1'b1, AW'(0), x};
    endfunction

    task automatic preload_pattern();
        for (int i = 0; i < N; i++) mem[i] = 32'(i) * 32'h01010101;
    endtask

    task automatic preload_random();
        mem[0] = '0;
        for (int i = 1; i < N; i++) mem[i] = $urandom;
    endtask

    // Runs one dump (two with chain) from a negedge, checking every cycle.
    task automatic run_dump(input int ready_pct, input int stall_idx,
                            input int restart_idx, input int write_idx,
                            input int abort_idx, input bit chain,
                            output int beats, output int dones,
                            output int first_done_t);
        logic [BW-1:0] obs, prev_obs;
        bit prev_hold, stalled, restarted, written, chained, active, ready;
        int exp_i, t, stall_left, exp_done_t, last_done_t, ndone_exp;
        beats = 0; dones = 0; first_done_t = -1; last_done_t = -1;
        prev_obs = '0; prev_hold = 0; stalled = 0; restarted = 0;
        written = 0; chained = 0; exp_i = 0; stall_left = 0;
        exp_done_t = -1; ndone_exp = chain ? 2 : 1;
        start = 1'b1; bus.out_ready = 1'b0; t = 0;
        @(negedge clk);
        t = 1; active = 1;
        while (t < 3000) begin
            start = 1'b0;
            obs = {bus.out_last, bus.out_csum, bus.out_idx, bus.out_data};
            vecs++;
            if (busy !== active) begin
                errs++; $display("FAIL busy t=%0d got %b exp %b", t, busy, active);
            end
            vecs++;
            if (done !== (t == exp_done_t)) begin
                errs++; $display("FAIL done t=%0d got %b exp %b", t, done, t == exp_done_t);
            end
            if (done) begin
                dones++;
                if (first_done_t < 0) first_done_t = t;
                last_done_t = t;
            end
            if (bus.out_valid) begin
                vecs++;
                if (obs !== exp_beat(exp_i)) begin
                    errs++; $display("FAIL beat%0d got %h exp %h", exp_i, obs, exp_beat(exp_i));
                end
                if (prev_hold) begin
                    vecs++;
                    if (obs !== prev_obs) begin
                        errs++; $display("FAIL hold t=%0d got %h exp %h", t, obs, prev_obs);
                    end
                end
            end
            if (abort_idx >= 0 && bus.out_valid && bus.out_idx == AW'(abort_idx)) begin
                rst = 1'b0;
                #1;
                vecs++;
                if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last,
                     bus.out_csum, busy, done, rd_addr} !== '0) begin
                    errs++; $display("FAIL abort_clear got v=%b d=%h i=%0d busy=%b done=%b exp all 0",
                                     bus.out_valid, bus.out_data, bus.out_idx, busy, done);
                end
                repeat (3) begin
                    @(negedge clk);
                    vecs++;
                    if ({busy, done, bus.out_valid} !== 3'b000) begin
                        errs++; $display("FAIL abort_idle got %b exp 000", {busy, done, bus.out_valid});
                    end
                end
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            if (restart_idx >= 0 && !restarted && bus.out_valid && bus.out_idx == AW'(restart_idx)) begin
                start = 1'b1; restarted = 1;
            end
            if (write_idx >= 0 && !written && bus.out_valid && bus.out_idx == AW'(15)) begin
                mem[write_idx] = 32'hDEADBEEF; written = 1;
            end
            if (stall_idx >= 0 && !stalled && bus.out_valid && bus.out_idx == AW'(stall_idx)) begin
                stall_left = 3; stalled = 1;
            end
            if (stall_left > 0) begin
                ready = 0; stall_left--;
            end else begin
                ready = (int'($urandom_range(99)) < ready_pct);
            end
            bus.out_ready = ready;
            if (bus.out_valid && ready) begin
                if (exp_i == NB - 1) begin
                    exp_done_t = t + 1; active = 0;
                end
                exp_i++; beats++;
            end
            if (chain && !chained && done) begin
                start = 1'b1; chained = 1; exp_i = 0;
            end
            if (start && !active) active = 1;
            prev_hold = bus.out_valid && !ready;
            prev_obs  = obs;
            if (dones == ndone_exp && t >= last_done_t + 4) break;
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
        if (t >= 3000) begin
            vecs++; errs++;
            $display("FAIL timeout got %0d dones exp %0d", dones, ndone_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
        preload_pattern();
        repeat (2) @(negedge clk);
        vecs++;
        if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last,
             bus.out_csum, busy, done, rd_addr} !== '0) begin
            errs++; $display("FAIL reset_vals got v=%b d=%h i=%0d busy=%b exp all 0",
                             bus.out_valid, bus.out_data, bus.out_idx, busy);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({busy, done, bus.out_valid, rd_addr} !== '0) begin
            errs++; $display("FAIL reset_idle got busy=%b done=%b v=%b a=%0d exp 0", busy, done, bus.out_valid, rd_addr);
        end
    endtask

    task automatic test_full_dump();
        int b, d, ft;
        preload_pattern();
        run_dump(100, -1, -1, -1, -1, 0, b, d, ft);
        vecs++; if (b !== NB) begin errs++; $display("FAIL full_beats got %0d exp %0d", b, NB); end
        vecs++; if (d !== 1) begin errs++; $display("FAIL full_dones got %0d exp 1", d); end
        vecs++; if (ft !== 2 * N + 1 + CS) begin errs++; $display("FAIL full_latency got %0d exp %0d", ft, 2 * N + 1 + CS); end
    endtask

    task automatic test_stall();
        int b, d, ft;
        preload_pattern();
        run_dump(100, 7, -1, -1, -1, 0, b, d, ft);
        vecs++; if (b !== NB) begin errs++; $display("FAIL stall_beats got %0d exp %0d", b, NB); end
        vecs++; if (d !== 1) begin errs++; $display("FAIL stall_dones got %0d exp 1", d); end
        vecs++; if (ft !== 2 * N + 4 + CS) begin errs++; $display("FAIL stall_latency got %0d exp %0d", ft, 2 * N + 4 + CS); end
    endtask

    task automatic test_start_ignored();
        int b, d, ft;
        preload_pattern();
        run_dump(100, -1, 10, -1, -1, 0, b, d, ft);
        vecs++; if (b !== NB) begin errs++; $display("FAIL busy_start_beats got %0d exp %0d", b, NB); end
        vecs++; if (d !== 1) begin errs++; $display("FAIL busy_start_dones got %0d exp 1", d); end
        vecs++; if (ft !== 2 * N + 1 + CS) begin errs++; $display("FAIL busy_start_latency got %0d exp %0d", ft, 2 * N + 1 + CS); end
    endtask

    task automatic test_reset_mid();
        int b, d, ft;
        preload_pattern();
        run_dump(100, -1, -1, -1, 15, 0, b, d, ft);
        vecs++; if (b !== 15) begin errs++; $display("FAIL abort_beats got %0d exp 15", b); end
        vecs++; if (d !== 0) begin errs++; $display("FAIL abort_dones got %0d exp 0", d); end
        run_dump(70, -1, -1, -1, -1, 0, b, d, ft);
        vecs++; if (b !== NB) begin errs++; $display("FAIL after_abort_beats got %0d exp %0d", b, NB); end
        vecs++; if (d !== 1) begin errs++; $display("FAIL after_abort_dones got %0d exp 1", d); end
    endtask

    task automatic test_write_mid();
        int b, d, ft;
        preload_random();
        run_dump(100, -1, -1, 20, -1, 0, b, d, ft);
        vecs++; if (b !== NB) begin errs++; $display("FAIL write_beats got %0d exp %0d", b, NB); end
        vecs++; if (d !== 1) begin errs++; $display("FAIL write_dones got %0d exp 1", d); end
    endtask

    task automatic test_random_backpressure();
        int b, d, ft;
        for (int r = 0; r < 3; r++) begin
            preload_random();
            run_dump(50, -1, -1, -1, -1, 0, b, d, ft);
            vecs++; if (b !== NB) begin errs++; $display("FAIL bp%0d_beats got %0d exp %0d", r, b, NB); end
            vecs++; if (d !== 1) begin errs++; $display("FAIL bp%0d_dones got %0d exp 1", r, d); end
        end
    endtask

    task automatic test_back_to_back();
        int b, d, ft;
        preload_random();
        run_dump(100, -1, -1, -1, -1, 1, b, d, ft);
        vecs++; if (b !== 2 * NB) begin errs++; $display("FAIL b2b_beats got %0d exp %0d", b, 2 * NB); end
        vecs++; if (d !== 2) begin errs++; $display("FAIL b2b_dones got %0d exp 2", d); end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_full_dump();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_write_mid();
        test_random_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
